// File: rtl/iob_ext_mem_arbiter.sv
// Round-robin arbiter sharing one IOb native slave port between N_MASTERS masters.
// Optional build macro IOB_ARB_TIMEOUT_EN adds a BUSY watchdog with a sticky timeout_err flag.
module iob_ext_mem_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
`ifdef IOB_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_MASTERS-1:0]              m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]       m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic [N_MASTERS-1:0]              m_ready,
  output logic                              s_valid,
  output logic [ADDR_W-1:0]                 s_addr,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  input  logic [DATA_W-1:0]                 s_rdata,
  input  logic                              s_ready,
  output logic [N_MASTERS-1:0]              grant,
  output logic                              busy
`ifdef IOB_ARB_TIMEOUT_EN
  , output logic                            timeout_err
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state, state_nxt;
  logic [N_MASTERS-1:0] grant_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_nxt;
  logic [PTR_W-1:0]     gidx, gidx_nxt;
  logic [PTR_W-1:0]     gidx_inc;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     idx;
  logic [PTR_W:0]       sum;
  logic                 found;
  logic                 done_c;
  logic                 expire_c;

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic             terr_nxt;

  assign expire_c = (state == BUSY) && !s_ready && (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire_c = 1'b0;
`endif

  assign busy    = (state == BUSY);
  assign s_valid = (state == BUSY);
  assign done_c  = (state == BUSY) && (s_ready || expire_c);
  assign m_ready = done_c ? grant : '0;
  // Forced (timeout) completions return zero data.
  assign m_rdata = ((state == BUSY) && s_ready) ? s_rdata : '0;

  // Index following the granted master, wrapping to 0.
  always_comb begin
    if (gidx == PTR_W'(N_MASTERS - 1)) gidx_inc = '0;
    else                               gidx_inc = gidx + PTR_W'(1);
  end

  // First valid master at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_MASTERS)) sum = sum - (PTR_W+1)'(N_MASTERS);
      idx = sum[PTR_W-1:0];
      if (!found && m_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // One-hot grant makes an OR-mux; zero grant in IDLE zeroes the slave fields.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (grant[i]) begin
        s_addr  = s_addr  | m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = s_wdata | m_wdata[i*DATA_W +: DATA_W];
        s_wstrb = s_wstrb | m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    gidx_nxt  = gidx;
`ifdef IOB_ARB_TIMEOUT_EN
    tcnt_nxt  = tcnt;
    terr_nxt  = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = N_MASTERS'(1) << sel;
          gidx_nxt  = sel;
`ifdef IOB_ARB_TIMEOUT_EN
          tcnt_nxt  = '0;
`endif
        end
      end
      BUSY: begin
        if (done_c) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_nxt    = gidx_inc;
`ifdef IOB_ARB_TIMEOUT_EN
          terr_nxt  = timeout_err | expire_c;
`endif
        end else begin
`ifdef IOB_ARB_TIMEOUT_EN
          tcnt_nxt  = tcnt + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      gidx        <= '0;
`ifdef IOB_ARB_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      rr_ptr      <= rr_nxt;
      gidx        <= gidx_nxt;
`ifdef IOB_ARB_TIMEOUT_EN
      tcnt        <= tcnt_nxt;
      timeout_err <= terr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// Self-checking bench for iob_ext_mem_arbiter (2 masters, 32-bit); timeout cases need IOB_ARB_TIMEOUT_EN.
module tb_iob_ext_mem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef struct {
    int unsigned   m;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int unsigned   lat;
    logic [DW-1:0] rdata;
    logic [N-1:0]  exp_grant;
  } vec_t;

  typedef struct {
    logic [N-1:0]  ready;
    logic [DW-1:0] rdata;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef IOB_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  iob_ext_mem_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef IOB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy)
`ifdef IOB_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pop_chk(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'(m_ready), 64'(0));
    end else begin
      e = sb.pop_front();
      chk({name, "_ready"}, 64'(m_ready), 64'(e.ready));
      chk({name, "_rdata"}, 64'(m_rdata), 64'(e.rdata));
    end
  endtask

  // One transaction: request in IDLE, slave answers after v.lat BUSY cycles.
  task automatic run_txn(input vec_t v);
    step();
    m_valid[v.m]             = 1'b1;
    m_addr[v.m*AW +: AW]     = v.addr;
    m_wdata[v.m*DW +: DW]    = v.wdata;
    m_wstrb[v.m*SW +: SW]    = v.wstrb;
    sb.push_back('{ready: v.exp_grant, rdata: v.rdata});
    smp();
    chk("idle_svalid", 64'(s_valid), 64'(0));
    for (int k = 0; k <= int'(v.lat); k++) begin
      if (k > 0 || 1) step();
      if (k == int'(v.lat)) begin
        s_ready = 1'b1;
        s_rdata = v.rdata;
      end
      smp();
      if (k == 0) begin
        chk("busy_svalid", 64'(s_valid), 64'(1));
        chk("busy_grant", 64'(grant), 64'(v.exp_grant));
        chk("fwd_addr", 64'(s_addr), 64'(v.addr));
        chk("fwd_wdata", 64'(s_wdata), 64'(v.wdata));
        chk("fwd_wstrb", 64'(s_wstrb), 64'(v.wstrb));
      end
      if (k < int'(v.lat)) chk("wait_noready", 64'(m_ready), 64'(0));
      else pop_chk("txn");
    end
    step();
    s_ready    = 1'b0;
    s_rdata    = '0;
    m_valid    = '0;
    smp();
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_ready", 64'(m_ready), 64'(0));
  endtask

  initial begin
    int   done;
    vec_t v;

    vecs[0] = '{m: 0, addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'b0000, lat: 3,
                rdata: 32'hCAFE_F00D, exp_grant: 2'b01};
    vecs[1] = '{m: 1, addr: 32'h0000_2000, wdata: 32'h1234_5678, wstrb: 4'b0011, lat: 1,
                rdata: 32'h55AA_55AA, exp_grant: 2'b10};
    vecs[2] = '{m: 1, addr: 32'h0000_3000, wdata: 32'h0, wstrb: 4'b0000, lat: 0,
                rdata: 32'h0BAD_BEEF, exp_grant: 2'b10};
    vecs[3] = '{m: 0, addr: 32'hFFFF_FFFC, wdata: 32'hDEAD_BEEF, wstrb: 4'b1111, lat: 5,
                rdata: 32'h1111_2222, exp_grant: 2'b01};

    rst     = 1'b0;
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    s_ready = 1'b0;
    step();
    step();
    smp();
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_svalid", 64'(s_valid), 64'(0));
    chk("rst_mready", 64'(m_ready), 64'(0));
    chk("rst_saddr", 64'(s_addr), 64'(0));
    chk("rst_mrdata", 64'(m_rdata), 64'(0));
`ifdef IOB_ARB_TIMEOUT_EN
    chk("rst_terr", 64'(timeout_err), 64'(0));
`endif

    // Contention: both masters request from reset, 1-cycle slave.
    m_valid = 2'b11;
    m_addr  = {32'h0000_1111, 32'h0000_0000};
    for (int i = 0; i < 8; i++)
      sb.push_back('{ready: (i % 2 == 0) ? 2'b01 : 2'b10, rdata: 32'hA000_0000 + 32'(i)});
    step();
    rst  = 1'b1;
    done = 0;
    for (int c = 0; c < 60 && done < 8; c++) begin
      step();
      s_ready = busy;
      s_rdata = 32'hA000_0000 + 32'(done);
      smp();
      if (m_ready != '0) begin
        pop_chk("contend");
        done++;
      end
    end
    chk("contend_count", 64'(done), 64'(8));
    step();
    m_valid = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    m_addr  = '0;
    step();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Stray s_ready while idle.
    step();
    s_ready = 1'b1;
    s_rdata = 32'h7777_7777;
    smp();
    chk("stray_mready", 64'(m_ready), 64'(0));
    chk("stray_busy", 64'(busy), 64'(0));
    step();
    s_ready = 1'b0;
    smp();
    chk("stray_busy2", 64'(busy), 64'(0));

    // Reset mid-BUSY; serve master 0 first so rr points at master 1.
    v = vecs[0];
    run_txn(v);
    step();
    m_valid             = 2'b10;
    m_addr[AW +: AW]    = 32'h0000_4000;
    step();
    smp();
    chk("rb_grant", 64'(grant), 64'(2'b10));
    step();
    step();
    rst     = 1'b0;
    m_valid = '0;
    smp();
    chk("rb_busy", 64'(busy), 64'(0));
    chk("rb_svalid", 64'(s_valid), 64'(0));
    chk("rb_grant0", 64'(grant), 64'(0));
    chk("rb_saddr", 64'(s_addr), 64'(0));
    step();
    step();
    rst     = 1'b1;
    s_ready = 1'b1;
    s_rdata = 32'h9999_9999;
    smp();
    chk("rb_late_mready", 64'(m_ready), 64'(0));
    chk("rb_late_busy", 64'(busy), 64'(0));
    step();
    s_ready = 1'b0;
    m_valid = 2'b11;
    step();
    smp();
    chk("rb_restart_grant", 64'(grant), 64'(2'b01));
    s_ready = 1'b1;
    s_rdata = 32'h4242_4242;
    #1;
    chk("rb_restart_ready", 64'(m_ready), 64'(2'b01));
    step();
    s_ready = 1'b0;
    m_valid = '0;
    m_addr  = '0;
    smp();
    chk("rb_end_busy", 64'(busy), 64'(0));

`ifdef IOB_ARB_TIMEOUT_EN
    // Slave never answers: forced completion on the 8th BUSY cycle.
    step();
    m_valid[0]    = 1'b1;
    m_addr[0 +: AW] = 32'h0000_5000;
    s_rdata       = 32'hDEAD_0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      smp();
      if (k < 8) chk("to_wait_ready", 64'(m_ready), 64'(0));
      else begin
        chk("to_ready", 64'(m_ready), 64'(2'b01));
        chk("to_rdata", 64'(m_rdata), 64'(0));
        chk("to_terr_pre", 64'(timeout_err), 64'(0));
      end
    end
    step();
    m_valid = '0;
    smp();
    chk("to_terr", 64'(timeout_err), 64'(1));
    chk("to_idle", 64'(busy), 64'(0));
    step();
    s_ready = 1'b1;
    smp();
    chk("to_stray", 64'(m_ready), 64'(0));
    step();
    s_ready = 1'b0;
    step();
    smp();
    chk("to_sticky", 64'(timeout_err), 64'(1));
    rst = 1'b0;
    step();
    smp();
    chk("to_rst_clear", 64'(timeout_err), 64'(0));
    step();
    rst = 1'b1;
    v = '{m: 0, addr: 32'h0000_6000, wdata: 32'h0, wstrb: 4'b0000, lat: 7,
          rdata: 32'h600D_DA7A, exp_grant: 2'b01};
    run_txn(v);
    chk("to_edge_noerr", 64'(timeout_err), 64'(0));
`endif

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
